// File: rtl/gpio_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gpio_capture_fifo
// Purpose  : Watches the processor GPIO write port and captures only writes
//            whose address lies inside [BASE, LIMIT]. Accepted samples are
//            queued in a circular FIFO and drained over a valid/ready stream.
//            The block also reports overflow, counts captured samples and
//            raises done at the end of a run.
// Config   : GPIO_CAPTURE_OFFSET_EN - when defined, each entry also stores
//            (GPIOaddr - BASE) and out_offset presents it. When undefined,
//            out_offset is tied to 0.
// Ports    : clk, rst (async, active-low)
//            capture_en, GPIOaddr, GPIO, GPIOEn - GPIO write snoop
//            out_data, out_offset, out_valid, out_ready - output stream
//            captured, overflow, done - run status
// Revision : 1.0 - initial release
// ============================================================================
module gpio_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int BASE   = 152100,
    parameter int LIMIT  = 304199,
    parameter int DEPTH  = 16,
    parameter int TOTAL  = 152100,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic [ADDR_W-1:0] GPIOaddr,
    input  logic [DATA_W-1:0] GPIO,
    input  logic              GPIOEn,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  captured,
    output logic              overflow,
    output logic              done
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] c_LIMIT = ADDR_W'(LIMIT);
    localparam logic [CNT_W-1:0]  c_TOTAL = CNT_W'(TOTAL);
    localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [CNT_W-1:0]   r_captured;
    logic               r_overflow;

    logic w_in_window;
    logic w_qualified;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_in_window = (GPIOaddr >= c_BASE) && (GPIOaddr <= c_LIMIT);
    // Once the run is complete, in-window writes are ignored silently: they
    // are not qualified, so they can never be counted as drops.
    assign w_qualified = GPIOEn && capture_en && w_in_window && (r_captured < c_TOTAL);
    assign w_full      = (r_count == c_DEPTH);
    assign w_pop       = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push      = w_qualified && (!w_full || w_pop);
    assign w_drop      = w_qualified && !w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_captured <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_captured <= r_captured + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: every read is gated by a non-zero occupancy,
    // so a reset that clears the pointers also hides every stale entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= GPIO;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign captured  = r_captured;
    assign overflow  = r_overflow;
    // No pushes happen after captured reaches TOTAL, so once the FIFO has
    // drained this term holds until reset.
    assign done      = (r_captured == c_TOTAL) && (r_count == '0);

`ifdef GPIO_CAPTURE_OFFSET_EN
    logic [ADDR_W-1:0] r_mem_offset [DEPTH];
    logic [ADDR_W-1:0] w_offset;

    // The window check guarantees GPIOaddr >= BASE, so this never wraps.
    assign w_offset = GPIOaddr - c_BASE;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_offset[r_wr_ptr] <= w_offset;
        end
    end

    assign out_offset = out_valid ? r_mem_offset[r_rd_ptr] : '0;
`else
    assign out_offset = '0;
`endif

endmodule
`default_nettype wire

// File: doc/gpio_capture_fifo.md
# gpio_capture_fifo

Synthesizable capture unit for the processor's GPIO write port. It watches every GPIO write strobe and keeps only writes whose address falls inside a parametrised window. Accepted samples go into a FIFO, with an optional window offset, and drain through a valid/ready stream to an off-chip link or a frame sink. It replaces bench-side address filtering and adds flow control, overflow reporting, a completion count and a done flag.

## Interface
Parameters:
- DATA_W, 8, width of a GPIO sample
- ADDR_W, 32, width of the GPIO address
- BASE, 152100, lowest accepted address (inclusive)
- LIMIT, 304199, highest accepted address (inclusive); BASE <= LIMIT
- DEPTH, 16, FIFO entries; power of two, >= 2
- TOTAL, 152100, number of accepted samples that completes a capture run
- CNT_W, 20, width of the capture counter; 2^CNT_W > TOTAL

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- capture_en  in  1  when low, all GPIO writes are ignored
- GPIOaddr  in  ADDR_W  processor GPIO write address
- GPIO  in  DATA_W  processor GPIO write data
- GPIOEn  in  1  GPIO write strobe, one sample per cycle high
- out_data  out  DATA_W  head-of-FIFO sample
- out_offset  out  ADDR_W  head-of-FIFO address minus BASE
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when high with out_valid
- captured  out  CNT_W  number of samples accepted into FIFO
- overflow  out  1  sticky; a qualified write was dropped because the FIFO was full
- done  out  1  captured == TOTAL and FIFO empty

## Operation
- Qualified write: GPIOEn=1, capture_en=1, BASE <= GPIOaddr <= LIMIT (unsigned compare), and captured < TOTAL.
- Push: a qualified write is pushed when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs in the same cycle. A push increments captured by 1.
- A qualified write that cannot be pushed is dropped. It sets overflow, and captured is unchanged.
- Once captured == TOTAL, in-window writes are ignored silently. They are not counted and do not set overflow.
- Pop: out_valid & out_ready. The head advances and occupancy decrements.
- Push and pop in the same cycle leave occupancy unchanged.
- Storage: circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Offset: GPIOaddr - BASE, computed at push, ADDR_W bits, always non-negative.
- Output order is strictly push order. No reordering or coalescing.
- done is combinational from captured and occupancy. It stays high until reset.
- capture_en going low mid-run stops new pushes only. The FIFO continues draining.

## Timing
- Reset (rst=0, asynchronous): pointers, occupancy and captured = 0. overflow = 0, out_valid = 0, done = 0 (TOTAL > 0). out_data and out_offset = 0.
- Reset asserted mid-run discards FIFO contents immediately. No stale entry appears after release.
- Latency: a write pushed at edge N gives out_valid=1 after edge N, with data visible in the same cycle, when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle, sustained.
- out_data and out_offset are stable while out_valid=1 and out_ready=0.
- Full with a simultaneous pop: the push is accepted, no overflow, occupancy stays DEPTH.
- captured updates at the edge that performs the push. done rises in the cycle after the final pop, or after the final push if no entry is pending.

## Configuration
- GPIO_CAPTURE_OFFSET_EN defined: the FIFO stores {offset, data} per entry and out_offset carries the stored offset.
- GPIO_CAPTURE_OFFSET_EN undefined: the FIFO stores data only and out_offset is tied to 0. All other behaviour is identical.

## Test plan
- Window filter: write to addresses 152099, 152100, 304199 and 304200 with out_ready=1. Only 152100 and 304199 emerge, with offsets 0 and 152099. captured=2.
- Backpressure and overflow: out_ready=0 and 17 consecutive in-window writes with DEPTH=16. Occupancy reaches 16, the 17th write sets overflow, and captured=16. Draining then yields 16 samples in order.
- Full plus simultaneous pop: FIFO full, then out_ready=1 with an in-window write in the same cycle. The write is accepted, overflow stays 0, occupancy stays 16.
- Completion: TOTAL=4 and 6 in-window writes with out_ready=1. Exactly 4 are output, captured=4, overflow=0, and done=1 after the last pop.
- Async reset mid-run: FIFO holding 5 entries, pulse rst low between edges. out_valid, captured and overflow drop to 0 immediately, and nothing is output after release.
- Macro off: build without GPIO_CAPTURE_OFFSET_EN and rerun the window filter test. Data is identical and out_offset=0.
